// File: rtl/arf038b064e1r1w0cbbehraa4acw_swt_obs_misr.sv
// Observation-flop MISR: compacts obs_in into a signature for a counted run,
// then optionally shifts the signature out serially, MSB first.

module arf038b064e1r1w0cbbehraa4acw_swt_obs_misr_cell (
  input  logic prev,
  input  logic fb,
  input  logic poly,
  input  logic obs,
  output logic nxt
);
  assign nxt = prev ^ (fb & poly) ^ obs;
endmodule

module arf038b064e1r1w0cbbehraa4acw_swt_obs_misr #(
  parameter int                    OBS_FLOP_NUM = 1,
  parameter int                    MISR_WIDTH   = 16,
  parameter logic [MISR_WIDTH-1:0] MISR_POLY    = 16'h1021,
  parameter int                    CNT_W        = 16
) (
  input  logic                    clock,
  input  logic                    reset_b,
  input  logic [OBS_FLOP_NUM-1:0] obs_in,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_cycles,
  input  logic                    abort,
  input  logic                    shift_en,
  output logic [MISR_WIDTH-1:0]   signature,
  output logic                    sig_out,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, COMPACT, DONE, SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [MISR_WIDTH-1:0]   sig_q, sig_nxt, misr_nxt, obs_ext;
  logic [CNT_W-1:0]        cnt, cnt_nxt;

  assign obs_ext = MISR_WIDTH'(obs_in);

  // One cell per signature bit: shifted-in neighbour, polynomial tap, obs input.
  genvar i;
  generate
    for (i = 0; i < MISR_WIDTH; i++) begin : g_cell
      logic prev;
      if (i == 0) begin : g_lsb
        assign prev = 1'b0;
      end else begin : g_upper
        assign prev = sig_q[i-1];
      end
      arf038b064e1r1w0cbbehraa4acw_swt_obs_misr_cell u_cell (
        .prev (prev),
        .fb   (sig_q[MISR_WIDTH-1]),
        .poly (MISR_POLY[i]),
        .obs  (obs_ext[i]),
        .nxt  (misr_nxt[i])
      );
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    sig_nxt   = sig_q;
    cnt_nxt   = cnt;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            sig_nxt   = '0;
            cnt_nxt   = num_cycles;
            state_nxt = (num_cycles == '0) ? DONE : COMPACT;
          end else if (state == DONE && shift_en) begin
            cnt_nxt   = CNT_W'(MISR_WIDTH);
            state_nxt = SHIFT;
          end
        end
        COMPACT: begin
          sig_nxt = misr_nxt;
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
        SHIFT: begin
          sig_nxt = {sig_q[MISR_WIDTH-2:0], 1'b0};
          cnt_nxt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_b) begin
      state <= IDLE;
      sig_q <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sig_q <= sig_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign signature = sig_q;
  assign sig_out   = (state == SHIFT) & sig_q[MISR_WIDTH-1];
  assign busy      = (state == COMPACT) || (state == SHIFT);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_misr.sv
// Scoreboard bench: stimulus queues expected end-of-busy / done-rise events,
// a negedge monitor pops and compares them as the DUT presents them.

module tb_arf038b064e1r1w0cbbehraa4acw_swt_obs_misr;

  logic        clock = 1'b0;
  logic        reset_b;
  logic [3:0]  obs_in;
  logic        start;
  logic [15:0] num_cycles;
  logic        abort;
  logic        shift_en;
  logic [15:0] signature;
  logic        sig_out;
  logic        busy;
  logic        done;

  arf038b064e1r1w0cbbehraa4acw_swt_obs_misr #(
    .OBS_FLOP_NUM (4),
    .MISR_WIDTH   (16),
    .MISR_POLY    (16'h1021),
    .CNT_W        (16)
  ) dut (
    .clock      (clock),
    .reset_b    (reset_b),
    .obs_in     (obs_in),
    .start      (start),
    .num_cycles (num_cycles),
    .abort      (abort),
    .shift_en   (shift_en),
    .signature  (signature),
    .sig_out    (sig_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // kind 0: done rises; kind 1: busy falls
  typedef struct {
    logic        kind;
    int          cycles;
    logic [15:0] bits;
    logic        done;
    logic [15:0] sig;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic mon_en   = 1'b0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic push_busy_end(input int cyc, input logic [15:0] bits,
                               input logic dn, input logic [15:0] sig);
    exp_t e;
    e.kind = 1'b1; e.cycles = cyc; e.bits = bits; e.done = dn; e.sig = sig;
    sb.push_back(e);
  endtask

  task automatic push_done(input logic [15:0] sig);
    exp_t e;
    e.kind = 1'b0; e.cycles = 0; e.bits = '0; e.done = 1'b1; e.sig = sig;
    sb.push_back(e);
  endtask

  // Monitor
  logic        prev_busy = 1'b0;
  logic        prev_done = 1'b0;
  int          bcnt      = 0;
  logic [15:0] bits      = '0;

  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (prev_busy && !busy) begin
        if (sb.size() == 0) chk("unexpected_busy_end", 1, 0);
        else begin
          e = sb.pop_front();
          chk("busy_end_kind",   {31'b0, e.kind}, 1);
          chk("busy_end_cycles", bcnt, e.cycles);
          chk("busy_end_bits",   bits, e.bits);
          chk("busy_end_done",   done, e.done);
          chk("busy_end_sig",    signature, e.sig);
        end
      end
      if (!prev_done && done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("done_kind", {31'b0, e.kind}, 0);
          chk("done_sig",  signature, e.sig);
          chk("done_busy", busy, 0);
        end
      end
      if (busy && !prev_busy) begin
        bcnt = 1;
        bits = {15'b0, sig_out};
      end else if (busy) begin
        bcnt++;
        bits = {bits[14:0], sig_out};
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    reset_b = 1'b0; obs_in = '0; start = 1'b0; num_cycles = '0;
    abort = 1'b0; shift_en = 1'b0;
    repeat (3) tick();
    chk("reset_sig",     signature, 16'h0000);
    chk("reset_busy",    busy, 0);
    chk("reset_done",    done, 0);
    chk("reset_sig_out", sig_out, 0);
    reset_b = 1'b1;
    mon_en  = 1'b1;
    tick();

    // Two compactions of 4'h8
    push_busy_end(2, 16'h0000, 1'b1, 16'h0018);
    push_done(16'h0018);
    start = 1'b1; num_cycles = 16'd2; tick();
    start = 1'b0; obs_in = 4'h8; tick(); tick();
    obs_in = 4'h0;
    repeat (5) tick();
    chk("done_hold_sig",  signature, 16'h0018);
    chk("done_hold_done", done, 1);

    // Serial unload of 0x0018
    push_busy_end(16, 16'h0018, 1'b0, 16'h0000);
    shift_en = 1'b1; tick(); shift_en = 1'b0;
    n = 0;
    while (busy && n < 40) begin tick(); n++; end
    chk("shift_finished", busy, 0);
    tick();
    chk("idle_sig_out", sig_out, 0);

    // shift_en is ignored in IDLE
    shift_en = 1'b1; tick(); shift_en = 1'b0;
    repeat (3) tick();
    chk("shift_en_idle_busy", busy, 0);

    // 17 compactions, single 1 on the first, start ignored mid-run
    push_busy_end(17, 16'h0000, 1'b1, 16'h1021);
    push_done(16'h1021);
    start = 1'b1; num_cycles = 16'd17; tick();
    start = 1'b0; obs_in = 4'h1; tick();
    obs_in = 4'h0;
    repeat (4) tick();
    start = 1'b1; num_cycles = 16'd3;
    repeat (2) tick();
    start = 1'b0;
    repeat (9) tick();
    chk("cyc16_sig", signature, 16'h8000);
    repeat (3) tick();

    // start beats shift_en in DONE; num_cycles=0 stays in DONE with cleared signature
    start = 1'b1; shift_en = 1'b1; num_cycles = 16'd0; tick();
    start = 1'b0; shift_en = 1'b0;
    chk("prio_done", done, 1);
    chk("prio_busy", busy, 0);
    chk("prio_sig",  signature, 16'h0000);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_done_to_idle", done, 0);

    // num_cycles=0 from IDLE
    push_done(16'h0000);
    start = 1'b1; num_cycles = 16'd0; tick(); start = 1'b0;
    repeat (2) tick();
    abort = 1'b1; tick(); abort = 1'b0;

    // Abort (with start) on compaction cycle 3 of 10
    push_busy_end(3, 16'h0000, 1'b0, 16'h0011);
    start = 1'b1; num_cycles = 16'd10; tick();
    start = 1'b0; obs_in = 4'h8; tick();
    obs_in = 4'h1; tick();
    abort = 1'b1; start = 1'b1; tick();
    abort = 1'b0; start = 1'b0; obs_in = 4'h0;
    repeat (3) tick();
    chk("abort_sig",  signature, 16'h0011);
    chk("abort_done", done, 0);

    // Reset held two cycles mid-run
    push_busy_end(3, 16'h0000, 1'b0, 16'h0000);
    start = 1'b1; num_cycles = 16'd10; tick();
    start = 1'b0; obs_in = 4'hF; tick(); tick();
    reset_b = 1'b0; tick(); tick();
    chk("midrun_reset_sig",  signature, 16'h0000);
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    reset_b = 1'b1; obs_in = 4'h0;
    repeat (2) tick();

    // Maximum count: exactly 65535 compactions
    push_busy_end(65535, 16'h0000, 1'b1, 16'h0000);
    push_done(16'h0000);
    start = 1'b1; num_cycles = 16'hFFFF; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 70000) begin tick(); n++; end
    chk("max_run_done", done, 1);
    repeat (5) tick();

    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
